// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: valid/ready input from fetch, registered decoded bundle to execute.
// A one-entry skid buffer keeps if_ready a pure function of the state register.
module instruction_decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  input  logic        flush,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic        funct7_b5,
  output logic [31:0] imm,
  output logic        is_alu_reg,
  output logic        is_alu_imm,
  output logic        is_load,
  output logic        is_store,
  output logic        is_lui,
  output logic        is_auipc,
  output logic        beq,
  output logic        bneq,
  output logic        blt,
  output logic        bltu,
  output logic        bge,
  output logic        bgeu,
  output logic        jmp,
  output logic        illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [31:0] imm;
    logic        is_alu_reg;
    logic        is_alu_imm;
    logic        is_load;
    logic        is_store;
    logic        is_lui;
    logic        is_auipc;
    logic        beq;
    logic        bneq;
    logic        blt;
    logic        bltu;
    logic        bge;
    logic        bgeu;
    logic        jmp;
    logic        illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] pc, input logic [31:0] instr);
    dec_t        d;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    d           = '0;
    d.pc        = pc;
    d.rs1       = instr[19:15];
    d.rs2       = instr[24:20];
    d.rd        = instr[11:7];
    d.funct3    = instr[14:12];
    d.funct7_b5 = instr[30];
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u = {instr[31:12], 12'b0};
    imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    // Every supported opcode ends in 2'b11, so compressed encodings fall to default.
    case (instr[6:0])
      OP_REG:   d.is_alu_reg = 1'b1;
      OP_IMM:   begin d.is_alu_imm = 1'b1; d.imm = imm_i; end
      OP_LOAD:  begin d.is_load    = 1'b1; d.imm = imm_i; end
      OP_STORE: begin d.is_store   = 1'b1; d.imm = imm_s; end
      OP_LUI:   begin d.is_lui     = 1'b1; d.imm = imm_u; end
      OP_AUIPC: begin d.is_auipc   = 1'b1; d.imm = imm_u; end
      OP_JAL:   begin d.jmp        = 1'b1; d.imm = imm_j; end
      OP_JALR: begin
        if (instr[14:12] == 3'b000) begin
          d.jmp = 1'b1;
          d.imm = imm_i;
        end else begin
          d.illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        d.imm = imm_b;
        case (instr[14:12])
          3'b000:  d.beq  = 1'b1;
          3'b001:  d.bneq = 1'b1;
          3'b100:  d.blt  = 1'b1;
          3'b101:  d.bge  = 1'b1;
          3'b110:  d.bltu = 1'b1;
          3'b111:  d.bgeu = 1'b1;
          default: begin d.illegal = 1'b1; d.imm = '0; end
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  logic [1:0]  state_q, state_d;
  dec_t        main_q, main_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    main_d       = main_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    case (state_q)
      ST_EMPTY: begin
        if (if_valid) begin
          main_d  = decode(if_pc, if_instr);
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (id_ready) begin
          if (if_valid) begin
            main_d = decode(if_pc, if_instr);
          end else begin
            main_d  = '0;
            state_d = ST_EMPTY;
          end
        end else if (if_valid) begin
          skid_pc_d    = if_pc;
          skid_instr_d = if_instr;
          state_d      = ST_SKID;
        end
      end
      ST_SKID: begin
        if (id_ready) begin
          main_d       = decode(skid_pc_q, skid_instr_q);
          skid_instr_d = NOP_INSTR;
          state_d      = ST_FULL;
        end
      end
      default: begin
        main_d  = '0;
        state_d = ST_EMPTY;
      end
    endcase
    // A taken branch/jump kills the held entries and whatever fetch presents now.
    if (flush) begin
      main_d       = '0;
      skid_pc_d    = '0;
      skid_instr_d = NOP_INSTR;
      state_d      = ST_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      main_q       <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign if_ready   = (state_q != ST_SKID);
  assign id_valid   = (state_q != ST_EMPTY);
  assign id_pc      = main_q.pc;
  assign rs1        = main_q.rs1;
  assign rs2        = main_q.rs2;
  assign rd         = main_q.rd;
  assign funct3     = main_q.funct3;
  assign funct7_b5  = main_q.funct7_b5;
  assign imm        = main_q.imm;
  assign is_alu_reg = main_q.is_alu_reg;
  assign is_alu_imm = main_q.is_alu_imm;
  assign is_load    = main_q.is_load;
  assign is_store   = main_q.is_store;
  assign is_lui     = main_q.is_lui;
  assign is_auipc   = main_q.is_auipc;
  assign beq        = main_q.beq;
  assign bneq       = main_q.bneq;
  assign blt        = main_q.blt;
  assign bltu       = main_q.bltu;
  assign bge        = main_q.bge;
  assign bgeu       = main_q.bgeu;
  assign jmp        = main_q.jmp;
  assign illegal    = main_q.illegal;

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Pipeline stage directly downstream of instruction fetch. It accepts a fetched (pc, instruction) pair through a valid/ready handshake and decodes RV32I fields, immediates and instruction class. It presents the result as a registered, valid-qualified bundle to execute, including the branch/jump class flags consumed by fetch and the branch comparator. A one-entry skid buffer keeps `if_ready` registered, so back-pressure never forms a combinational path back into fetch.

## Interface
- `NOP_INSTR`, 32'h00000013, raw instruction value held in empty/flushed entries.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `if_valid`  in  1  fetch presents a valid instruction.
- `if_pc`  in  32  pc of presented instruction.
- `if_instr`  in  32  presented instruction word.
- `if_ready`  out  1  stage accepts this cycle; transfer = `if_valid & if_ready`.
- `flush`  in  1  kill all held and incoming instructions (taken branch/jump).
- `id_ready`  in  1  execute consumes `id_*` this cycle.
- `id_valid`  out  1  `id_*` bundle valid.
- `id_pc`  out  32  pc of decoded instruction.
- `rs1`, `rs2`, `rd`  out  5 each  register fields, instr[19:15], [24:20], [11:7].
- `funct3`  out  3  instr[14:12]; `funct7_b5` out 1  instr[30].
- `imm`  out  32  sign-extended immediate for the instruction format; 0 for R-type/illegal.
- `is_alu_reg`, `is_alu_imm`, `is_load`, `is_store`, `is_lui`, `is_auipc`  out  1 each  class flags.
- `beq`, `bneq`, `blt`, `bltu`, `bge`, `bgeu`  out  1 each  branch type (decoded, not resolved).
- `jmp`  out  1  JAL or JALR.
- `illegal`  out  1  unsupported encoding.

## Operation
- States: EMPTY (no entry), FULL (main register holds entry), SKID (main plus skid hold entries). `if_ready = (state != SKID)`, decoded from the state register only.
- EMPTY: `if_valid` → decode into main, go FULL.
- FULL:
  - `id_ready & if_valid` → main reloads, stay FULL.
  - `id_ready & !if_valid` → EMPTY.
  - `!id_ready & if_valid` → raw pc/instr into skid, go SKID.
  - `!id_ready & !if_valid` → hold.
- SKID: `id_ready` → skid decoded into main, go FULL. Otherwise hold. No accept, because `if_ready = 0`.
- `flush` has priority over every transition: next state EMPTY, incoming instruction discarded, main/skid raw words set to `NOP_INSTR`, `id_valid` 0.
- Opcode decode on instr[6:0]:
  - 0110011 → R.
  - 0010011 → I-ALU.
  - 0000011 → load.
  - 0100011 → store.
  - 1100011 → branch.
  - 1101111 → JAL.
  - 1100111 → JALR.
  - 0110111 → LUI.
  - 0010111 → AUIPC.
- Branch funct3 mapping: 000 beq, 001 bneq, 100 blt, 101 bge, 110 bltu, 111 bgeu.
- `illegal` is set when any of these hold: instr[1:0] != 2'b11, opcode unlisted, branch funct3 010/011, JALR funct3 != 000.
- When `illegal` is set, all class/branch flags are 0 and `imm` is 0. The entry still flows with `id_valid`.
- Immediates, sign bit instr[31]:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- Exactly one class flag, or `illegal`, is set per valid entry. Flags are undefined-free: all 0 when `id_valid` = 0.

## Timing
- Reset values: state EMPTY, `if_ready` 1, `id_valid` 0, `id_pc` 0, every other output 0.
- Reset asserted mid-stream drops all entries; there is no drain.
- Latency: an instruction accepted at edge N appears on `id_*` after edge N. Throughput is one per cycle while `id_ready` = 1.
- `id_*` is stable while `id_valid & !id_ready`.
- `if_ready` falls the cycle after the skid fills and rises the cycle after it drains.
- Ordering is strictly preserved: no loss, no duplication across skid transitions.
- `flush` and `id_ready` in the same cycle: flush wins. The current entry counts as consumed by execute; nothing is replayed.

## Test plan
- Reset for 2 cycles, then release → `id_valid` 0, `if_ready` 1, all outputs 0. With `if_valid` 0, the state stays EMPTY.
- `if_pc`=0x0, `if_instr`=0x00500093, `id_ready`=1 → next cycle `id_valid` 1, `rd` 1, `rs1` 0, `imm` 5, `is_alu_imm` 1.
- `if_instr`=0xFE208EE3 → `beq` 1, `rs1` 1, `rs2` 2, `imm` 0xFFFFFFFC. Repeat with funct3 010 → `illegal` 1, `beq` 0.
- `if_instr`=0x008000EF → `jmp` 1, `rd` 1, `imm` 0x00000008. `if_instr`=0x00000000 → `illegal` 1.
- `id_ready` 0, send pc 0x10, 0x14 back-to-back → pc 0x14 goes to skid and `if_ready` 0 the next cycle. Raise `id_ready` → outputs pc 0x10 then 0x14 on consecutive cycles, then `if_ready` returns to 1.
- In SKID, assert `flush` with `if_valid` 1 → next cycle `id_valid` 0, `if_ready` 1, state EMPTY. The flushed pcs never appear on `id_pc`.
